// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
//
// EX-stage branch resolution for the pipelined core, plus the branch history
// table (BHT) used by IF to predict conditional branches.
//
// The unit evaluates the six RV32I conditional branches (beq, bne, blt, bge,
// bltu, bgeu) on XLEN-wide operands. It flags a misprediction when the
// resolved outcome differs from the prediction that IF made for the same
// instruction. It also keeps two saturating statistics counters.
//
// The BHT is a direct-mapped table of 2-bit saturating counters:
//   - It is read combinationally with the fetch PC.
//   - It is written on the clock edge when an EX branch resolves.
//   - When the same entry is read and written in one cycle, the read returns
//     the pre-update value.
//
// There is no handshake on this block. The hazard unit holds or flushes the
// EX inputs itself, and this block simply evaluates what it is given each
// cycle.
//
// Parameters
//   XLEN      operand / PC width
//   IDX_BITS  BHT index width; the table holds 2**IDX_BITS entries
//   CNT_W     width of each statistics counter
//
// Ports
//   clk               single clock; all state updates on the rising edge
//   rst               synchronous, active-high reset
//   if_pc             fetch PC used for the prediction lookup
//   pred_taken        prediction for if_pc (counter MSB), combinational
//   ex_valid          EX holds a valid, non-flushed instruction
//   ex_pc             PC of the EX instruction (selects the BHT entry to train)
//   a, b              rs1 / rs2 operands after forwarding
//   br_ctrl           0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu,
//                     7 reserved
//   ex_pred_taken     prediction carried down the pipe for this instruction
//   br_true           resolved branch outcome, combinational
//   mispredict        resolved outcome differs from ex_pred_taken
//   stat_branches     saturating count of resolved branches
//   stat_mispredicts  saturating count of mispredictions
// -----------------------------------------------------------------------------
module branch_unit #(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [2:0]       br_ctrl,
    input  logic             ex_pred_taken,
    output logic             br_true,
    output logic             mispredict,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int DEPTH = 1 << IDX_BITS;

    // Encodings of br_ctrl.
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_EQ   = 3'd1;
    localparam logic [2:0] BR_NE   = 3'd2;
    localparam logic [2:0] BR_LT   = 3'd3;
    localparam logic [2:0] BR_GE   = 3'd4;
    localparam logic [2:0] BR_LTU  = 3'd5;
    localparam logic [2:0] BR_GEU  = 3'd6;
    localparam logic [2:0] BR_RSVD = 3'd7;

    // Counter state applied to every BHT entry on reset: weakly not-taken.
    localparam logic [1:0] BHT_RESET = 2'b01;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Comparators
    // -------------------------------------------------------------------------
    logic w_eq;
    logic w_lt_u;
    logic w_lt_s;

    assign w_eq   = (a == b);
    assign w_lt_u = (a < b);

    // Signed less-than without relying on the sign of a-b, which is wrong when
    // the subtraction overflows. The rule is:
    //   - If the signs differ, the negative operand (sign bit set) is smaller.
    //   - If the signs match, the unsigned order is also the signed order.
    assign w_lt_s = (a[XLEN-1] != b[XLEN-1]) ? a[XLEN-1] : w_lt_u;

    // -------------------------------------------------------------------------
    // Condition select
    //   w_is_branch : br_ctrl names one of the six real branch types
    //   w_cond      : the selected condition (0 for none / reserved)
    // -------------------------------------------------------------------------
    logic w_is_branch;
    logic w_cond;

    always_comb begin
        w_is_branch = 1'b0;
        w_cond      = 1'b0;
        case (br_ctrl)
            BR_EQ: begin
                w_is_branch = 1'b1;
                w_cond      = w_eq;
            end
            BR_NE: begin
                w_is_branch = 1'b1;
                w_cond      = !w_eq;
            end
            BR_LT: begin
                w_is_branch = 1'b1;
                w_cond      = w_lt_s;
            end
            BR_GE: begin
                w_is_branch = 1'b1;
                w_cond      = !w_lt_s;
            end
            BR_LTU: begin
                w_is_branch = 1'b1;
                w_cond      = w_lt_u;
            end
            BR_GEU: begin
                w_is_branch = 1'b1;
                w_cond      = !w_lt_u;
            end
            BR_NONE, BR_RSVD: begin
                w_is_branch = 1'b0;
                w_cond      = 1'b0;
            end
            default: begin
                w_is_branch = 1'b0;
                w_cond      = 1'b0;
            end
        endcase
    end

    // A branch resolves only for a valid EX instruction with a real branch
    // type. Gating the outcome by the resolve strobe also forces br_true to 0
    // when ex_valid is low.
    logic w_res;

    assign w_res      = ex_valid && w_is_branch;
    assign br_true    = w_res && w_cond;
    assign mispredict = w_res && (br_true != ex_pred_taken);

    // -------------------------------------------------------------------------
    // Branch history table
    // -------------------------------------------------------------------------
    logic [1:0]          r_bht [DEPTH];
    logic [IDX_BITS-1:0] w_if_idx;
    logic [IDX_BITS-1:0] w_ex_idx;
    logic [1:0]          w_bht_cur;
    logic [1:0]          w_bht_next;

    // Instructions are word aligned, so PC bits [1:0] carry no information
    // and are skipped when forming the index.
    assign w_if_idx = if_pc[IDX_BITS+1:2];
    assign w_ex_idx = ex_pc[IDX_BITS+1:2];

    // The lookup is a plain array read. The write below lands on the clock
    // edge, so a same-cycle read of the entry being trained sees the old
    // value.
    assign pred_taken = r_bht[w_if_idx][1];

    assign w_bht_cur = r_bht[w_ex_idx];

    // 2-bit saturating counter step:
    //   - Taken increments, holding at 3.
    //   - Not-taken decrements, holding at 0.
    always_comb begin
        w_bht_next = w_bht_cur;
        if (br_true) begin
            if (w_bht_cur != 2'b11) begin
                w_bht_next = w_bht_cur + 2'd1;
            end
        end else begin
            if (w_bht_cur != 2'b00) begin
                w_bht_next = w_bht_cur - 2'd1;
            end
        end
    end

    // Reset is tested first, so it wins over a concurrent update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bht[i] <= BHT_RESET;
            end
        end else if (w_res) begin
            r_bht[w_ex_idx] <= w_bht_next;
        end
    end

    // -------------------------------------------------------------------------
    // Statistics counters (saturate at all-ones, never wrap)
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] r_stat_branches;
    logic [CNT_W-1:0] r_stat_mispredicts;
    logic             w_branches_full;
    logic             w_mispredicts_full;

    assign w_branches_full    = &r_stat_branches;
    assign w_mispredicts_full = &r_stat_mispredicts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_res && !w_branches_full) begin
                r_stat_branches <= r_stat_branches + CNT_ONE;
            end
            if (mispredict && !w_mispredicts_full) begin
                r_stat_mispredicts <= r_stat_mispredicts + CNT_ONE;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;

    // PC bits outside the index field do not take part in the lookup.
    logic w_unused_pc_bits;

    assign w_unused_pc_bits = ^{if_pc[XLEN-1:IDX_BITS+2], if_pc[1:0],
                                ex_pc[XLEN-1:IDX_BITS+2], ex_pc[1:0]};

endmodule

// File: tb/tb_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_unit
//
// Drives two branch_unit instances from the same inputs:
//   - dut  uses the default CNT_W of 32.
//   - dut4 uses CNT_W = 4, so counter saturation shows up quickly.
//
// The reference model works from the branch rules directly:
//   - Operands are compared as mathematical integers.
//   - The table is an int array indexed by (pc / 4) mod depth.
//   - Statistics are plain counts, clipped to the counter range when compared.
// -----------------------------------------------------------------------------
module tb_branch_unit;

    localparam int XLEN  = 32;
    localparam int IDX   = 6;
    localparam int DEPTH = 64;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst           = 1'b1;
    logic [XLEN-1:0]  if_pc         = '0;
    logic             ex_valid      = 1'b0;
    logic [XLEN-1:0]  ex_pc         = '0;
    logic [XLEN-1:0]  a             = '0;
    logic [XLEN-1:0]  b             = '0;
    logic [2:0]       br_ctrl       = '0;
    logic             ex_pred_taken = 1'b0;

    logic             pred_taken;
    logic             br_true;
    logic             mispredict;
    logic [31:0]      stat_branches;
    logic [31:0]      stat_mispredicts;

    logic             pred_taken4;
    logic             br_true4;
    logic             mispredict4;
    logic [3:0]       stat_branches4;
    logic [3:0]       stat_mispredicts4;

    branch_unit #(.XLEN(XLEN), .IDX_BITS(IDX), .CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .a                (a),
        .b                (b),
        .br_ctrl          (br_ctrl),
        .ex_pred_taken    (ex_pred_taken),
        .br_true          (br_true),
        .mispredict       (mispredict),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    branch_unit #(.XLEN(XLEN), .IDX_BITS(IDX), .CNT_W(4)) dut4 (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken4),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .a                (a),
        .b                (b),
        .br_ctrl          (br_ctrl),
        .ex_pred_taken    (ex_pred_taken),
        .br_true          (br_true4),
        .mispredict       (mispredict4),
        .stat_branches    (stat_branches4),
        .stat_mispredicts (stat_mispredicts4)
    );

    // ---------------------------------------------------------------------
    // Reference model state and scoreboard counters
    // ---------------------------------------------------------------------
    int     m_bht [DEPTH];
    longint m_branches;
    longint m_mispredicts;
    int     total = 0;
    int     bad   = 0;

    function automatic longint as_signed(input logic [31:0] v);
        longint u;
        u = longint'(v);
        return (u >= 64'sh8000_0000) ? (u - 64'sh1_0000_0000) : u;
    endfunction

    function automatic longint clip(input longint n, input int w);
        longint top;
        top = (longint'(1) <<< w) - 1;
        return (n > top) ? top : n;
    endfunction

    function automatic int bht_index(input logic [31:0] pc);
        return int'((longint'(pc) / 4) % DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Driver + model step
    //   1. Apply the inputs at the falling edge.
    //   2. Check the combinational outputs and the current state.
    //   3. Let the rising edge happen, then advance the model.
    // The inputs stay applied until the next call.
    // ---------------------------------------------------------------------
    task automatic step(input logic r, input logic v, input logic [31:0] epc,
                        input logic [31:0] ia, input logic [31:0] ib,
                        input logic [2:0] c, input logic p, input logic [31:0] ipc);
        bit     res;
        bit     cond;
        bit     exp_bt;
        bit     exp_mp;
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        int     ei;

        @(negedge clk);
        rst           = r;
        ex_valid      = v;
        ex_pc         = epc;
        a             = ia;
        b             = ib;
        br_ctrl       = c;
        ex_pred_taken = p;
        if_pc         = ipc;
        #1;

        sa = as_signed(ia);
        sb = as_signed(ib);
        ua = longint'(ia);
        ub = longint'(ib);

        case (c)
            3'd1:    cond = (ua == ub);
            3'd2:    cond = (ua != ub);
            3'd3:    cond = (sa <  sb);
            3'd4:    cond = (sa >= sb);
            3'd5:    cond = (ua <  ub);
            3'd6:    cond = (ua >= ub);
            default: cond = 1'b0;
        endcase

        res    = v && (c >= 3'd1) && (c <= 3'd6);
        exp_bt = res && cond;
        exp_mp = res && (exp_bt != p);

        chk("br_true",        br_true,           exp_bt);
        chk("mispredict",     mispredict,        exp_mp);
        chk("pred_taken",     pred_taken,        m_bht[bht_index(ipc)] >= 2);
        chk("pred_taken_w4",  pred_taken4,       m_bht[bht_index(ipc)] >= 2);
        chk("stat_br",        stat_branches,     clip(m_branches, 32));
        chk("stat_mp",        stat_mispredicts,  clip(m_mispredicts, 32));
        chk("stat_br_w4",     stat_branches4,    clip(m_branches, 4));
        chk("stat_mp_w4",     stat_mispredicts4, clip(m_mispredicts, 4));

        @(posedge clk);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
            m_branches   = 0;
            m_mispredicts = 0;
        end else if (res) begin
            ei = bht_index(epc);
            if (exp_bt) m_bht[ei] = (m_bht[ei] == 3) ? 3 : m_bht[ei] + 1;
            else        m_bht[ei] = (m_bht[ei] == 0) ? 0 : m_bht[ei] - 1;
            m_branches++;
            if (exp_mp) m_mispredicts++;
        end
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        // The model starts at the reset state; the first steps apply reset.
        for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
        m_branches    = 0;
        m_mispredicts = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Reset state: no prediction, zero stats, idle outputs.
        step(0, 0, 0, 0, 0, 0, 0, 32'h40);
        chk("rst_pred",  pred_taken,    0);
        chk("rst_stat",  stat_branches, 0);
        chk("rst_brt",   br_true,       0);

        // Signed vs unsigned compare on 0x80000000 vs 1.
        step(0, 1, 32'h200, 32'h8000_0000, 32'h1, 3'd3, 0, 0);
        chk("tp_blt",  br_true, 1);
        step(0, 1, 32'h200, 32'h8000_0000, 32'h1, 3'd5, 0, 0);
        chk("tp_bltu", br_true, 0);
        step(0, 1, 32'h200, 32'h8000_0000, 32'h1, 3'd4, 0, 0);
        chk("tp_bge",  br_true, 0);
        step(0, 1, 32'h200, 32'h8000_0000, 32'h1, 3'd6, 0, 0);
        chk("tp_bgeu", br_true, 1);

        // Overflow case: the sign of a-b alone would give the wrong answer.
        step(0, 1, 32'h200, 32'h7FFF_FFFF, 32'h8000_0000, 3'd3, 0, 0);
        chk("tp_blt_ovf", br_true, 0);

        // Counter saturation on entry 16: four taken, then four not-taken.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 32'h40, 32'd5, 32'd5, 3'd1, 0, 32'h40);
            chk("sat_up_pred", pred_taken, 1);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 32'h40, 32'd5, 32'd6, 3'd1, 1, 32'h40);
        end
        chk("sat_down_pred", pred_taken, 0);

        // Mispredict, then the stats one cycle later.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h80, 32'd1, 32'd2, 3'd2, 0, 32'h80);
        chk("mp_flag",   mispredict,       1);
        chk("mp_st_br",  stat_branches,    1);
        chk("mp_st_mp",  stat_mispredicts, 1);

        // The same inputs with ex_valid low change nothing.
        step(0, 0, 32'h80, 32'd1, 32'd2, 3'd2, 0, 32'h80);
        chk("inv_st_br", stat_branches, 1);
        chk("inv_pred",  pred_taken,    1);

        // Read-before-write on a shared index.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h100, 32'd3, 32'd3, 3'd1, 1, 32'h100);
        chk("rbw_after", pred_taken, 1);

        // Reset wins over a concurrent resolved, taken mispredict.
        step(1, 1, 32'h100, 32'd3, 32'd3, 3'd1, 0, 32'h100);
        chk("rstpri_br", stat_branches,    0);
        chk("rstpri_mp", stat_mispredicts, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 32'(i * 4));
        end

        // Reserved br_ctrl with ex_valid high.
        step(0, 1, 32'h10, 32'd9, 32'd9, 3'd7, 1, 32'h10);
        chk("rsvd_brt", br_true, 0);
        chk("rsvd_st",  stat_branches, 0);

        // 20 resolved branches saturate the 4-bit counter at 15.
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 32'(k * 4), $urandom, $urandom,
                 3'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 32'(k * 4));
        end
        chk("w4_sat", stat_branches4, 15);

        // Randomised traffic with occasional reset.
        for (int k = 0; k < 400; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = ra;
                1:       rb = ra ^ 32'h8000_0000;
                2:       rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 7) != 0),
                 32'($urandom_range(0, 1023)) << 2,
                 ra, rb,
                 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 1023)) << 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised EX-stage branch resolution unit for the pipelined core. It evaluates the full RV32I conditional-branch set, including the unsigned forms and overflow-correct signed forms, on XLEN-wide operands. It also owns a direct-mapped branch history table (BHT) of 2-bit saturating counters: the table is read in IF to predict, and updated in EX when the branch resolves. It flags mispredictions so the hazard unit can flush, and keeps saturating performance counters.

## Interface
- XLEN, 32, operand and PC width
- IDX_BITS, 6, BHT index width; table depth = 2**IDX_BITS
- CNT_W, 32, width of each statistics counter
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- if_pc  input  XLEN  fetch PC for prediction lookup
- pred_taken  output  1  IF prediction for if_pc
- ex_valid  input  1  EX stage holds a valid, non-flushed instruction
- ex_pc  input  XLEN  PC of the EX instruction
- a  input  XLEN  rs1 operand (post-forwarding)
- b  input  XLEN  rs2 operand (post-forwarding)
- br_ctrl  input  3  0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu, 7 reserved
- ex_pred_taken  input  1  prediction made for this instruction in IF, carried down the pipe
- br_true  output  1  resolved branch outcome
- mispredict  output  1  resolved outcome differs from ex_pred_taken
- stat_branches  output  CNT_W  count of resolved branches
- stat_mispredicts  output  CNT_W  count of mispredictions

## Operation
- Compare rules:
  - eq = (a == b).
  - lt_s = signed a < signed b. This is a true signed compare; the sign bit of a-b is not used alone.
  - lt_u = unsigned a < unsigned b.
  - beq uses eq, bne uses !eq, blt uses lt_s, bge uses !lt_s, bltu uses lt_u, bgeu uses !lt_u.
  - br_ctrl 0 or 7 gives br_true = 0.
- A branch is resolved when res = ex_valid && br_ctrl in 1..6.
- br_true is gated by ex_valid; it is 0 when ex_valid = 0.
- mispredict = res && (br_true != ex_pred_taken). It is 0 whenever res = 0.
- BHT:
  - Depth 2**IDX_BITS entries of 2 bits each.
  - Lookup index = if_pc[IDX_BITS+1:2]. Update index = ex_pc[IDX_BITS+1:2].
  - pred_taken = counter[1] of the looked-up entry.
  - On res: if br_true, the counter increments, saturating at 3. Otherwise it decrements, saturating at 0.
  - No BHT update when res = 0.
- Statistics:
  - stat_branches increments on every res cycle.
  - stat_mispredicts increments on every mispredict cycle.
  - Both saturate at all-ones and never wrap.

## Timing
- br_true, mispredict and pred_taken are combinational. There is zero-cycle latency from their inputs.
- BHT and statistics counters update on the rising clk edge after res/mispredict are sampled. Updated values are visible the following cycle.
- Same-cycle read/write to the same BHT index: pred_taken returns the old (pre-update) value, i.e. read-before-write.
- rst = 1 at a rising edge:
  - Every BHT entry goes to 2'b01 (weakly not-taken).
  - Both stat counters go to 0.
  - Reset has priority over any concurrent update.
- Outputs after reset:
  - pred_taken = 0 for any PC.
  - stat outputs = 0.
  - br_true and mispredict follow their inputs (0 with ex_valid = 0).
- Reset asserted mid-operation discards that cycle's update entirely.
- No handshake: the hazard unit is responsible for holding or flushing the EX inputs on a stall.

## Test plan
- Signed/unsigned compare: a=0x80000000, b=0x00000001.
  - blt -> br_true=1; bltu -> 0; bge -> 0; bgeu -> 1.
  - Overflow case a=0x7FFFFFFF, b=0x80000000 with blt -> br_true=0.
- Counter saturation: reset, then 4 taken beq (a=b=5) at ex_pc=0x40.
  - Entry 16 goes 01->10->11->11->11.
  - if_pc=0x40 gives pred_taken=1 from the cycle after the first update.
  - Then 4 not-taken drive the entry 11->10->01->00->00.
- Mispredict and stats: ex_pred_taken=0 with a taken bne (a=1, b=2) -> mispredict=1.
  - Next cycle stat_branches=1, stat_mispredicts=1.
  - ex_valid=0 with the same inputs -> no change to BHT or stats.
- Read-before-write: if_pc = ex_pc = 0x100, entry at 01, taken branch resolves.
  - Same cycle pred_taken=0; next cycle pred_taken=1.
- Reset priority: rst=1 in the same cycle as a resolved taken mispredict.
  - Next cycle: stats=0 and all entries read pred_taken=0.
- Reserved and saturation: br_ctrl=7, ex_valid=1 -> br_true=0, no stat increment.
  - With CNT_W=4, 20 resolved branches leave stat_branches=15.
